// File: rtl/four_bit_sar_search.sv
// Successive-approximation search: recovers a hidden value A one bit per accepted
// response from an external magnitude comparator, MSB first, with early exit on equality.
module four_bit_sar_search #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [WIDTH-1:0]             guess,
  output logic                         guess_valid,
  input  logic                         cmp_valid,
  input  logic                         a_gt_b,
  input  logic                         a_lt_b,
  input  logic                         a_eq_b,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             result,
  output logic [$clog2(WIDTH+1)-1:0]   probes,
  output logic                         err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] working, working_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [PW-1:0]    probes_nxt;
  logic             err_nxt;
  logic [WIDTH-1:0] trial;
  logic             accept;
  logic             well_formed;

  assign trial  = working | (WIDTH'(1) << idx);
  assign accept = (state == PROBE) && cmp_valid;

  always_comb begin
    well_formed = 1'b0;
    case ({a_gt_b, a_lt_b, a_eq_b})
      3'b100, 3'b010, 3'b001: well_formed = 1'b1;
      default:                well_formed = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    working_nxt = working;
    idx_nxt     = idx;
    probes_nxt  = probes;
    err_nxt     = err;
    result_nxt  = result;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = PROBE;
          working_nxt = '0;
          idx_nxt     = IW'(WIDTH - 1);
          probes_nxt  = '0;
          err_nxt     = 1'b0;
          result_nxt  = '0;
        end
      end
      PROBE: begin
        if (accept) begin
          probes_nxt = probes + PW'(1);
          if (!well_formed) begin
            result_nxt = '0;
            err_nxt    = 1'b1;
            state_nxt  = FINISH;
          end else if (a_eq_b) begin
            working_nxt = trial;
            result_nxt  = trial;
            state_nxt   = FINISH;
          end else begin
            // lt leaves bit i clear since working never has it set yet
            working_nxt = a_gt_b ? trial : working;
            if (idx == '0) begin
              result_nxt = a_gt_b ? trial : working;
              state_nxt  = FINISH;
            end else begin
              idx_nxt = idx - IW'(1);
            end
          end
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      working <= '0;
      idx     <= '0;
      probes  <= '0;
      err     <= 1'b0;
      result  <= '0;
    end else begin
      state   <= state_nxt;
      working <= working_nxt;
      idx     <= idx_nxt;
      probes  <= probes_nxt;
      err     <= err_nxt;
      result  <= result_nxt;
    end
  end

  assign guess_valid = (state == PROBE);
  assign guess       = guess_valid ? trial : '0;
  assign busy        = (state == PROBE);
  assign done        = (state == FINISH);

endmodule

// File: tb/tb_four_bit_sar_search.sv
// Bench for four_bit_sar_search: acts as the external comparator and checks every
// guess and completion against an arithmetic binary-search reference.
module tb_four_bit_sar_search;

  localparam int W  = 4;
  localparam int PW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  guess;
  logic          guess_valid;
  logic          cmp_valid = 1'b0;
  logic          a_gt_b = 1'b0;
  logic          a_lt_b = 1'b0;
  logic          a_eq_b = 1'b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [PW-1:0] probes;
  logic          err;

  int checks = 0;
  int errors = 0;

  four_bit_sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .guess(guess), .guess_valid(guess_valid), .cmp_valid(cmp_valid),
    .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
    .busy(busy), .done(done), .result(result), .probes(probes), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_flags();
    cmp_valid = 1'b0;
    a_gt_b = 1'b0;
    a_lt_b = 1'b0;
    a_eq_b = 1'b0;
  endtask

  // Expected guess at bit i: A's bits above i already resolved, bit i set, rest clear.
  function automatic int model_guess(input int a, input int i);
    return ((a >> (i + 1)) << (i + 1)) | (1 << i);
  endfunction

  // One full search for hidden value a; bad_at (1-based) injects gt&lt on that probe.
  task automatic run_search(input int a, input int stall, input int bad_at, input bit mid_start);
    int  i, n, exp_g;
    bit  fin, bad;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    i = W - 1; n = 0; fin = 1'b0; bad = 1'b0;
    while (!fin) begin
      exp_g = model_guess(a, i);
      check("guess", guess, exp_g);
      check("guess_valid", guess_valid, 1);
      if (n == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          check("stall_guess_hold", guess, exp_g);
          check("stall_gvalid_hold", guess_valid, 1);
        end
      end
      if (mid_start && n == 1) start = 1'b1;
      n++;
      cmp_valid = 1'b1;
      if (n == bad_at) begin
        a_gt_b = 1'b1; a_lt_b = 1'b1; a_eq_b = 1'b0;
        bad = 1'b1; fin = 1'b1;
      end else begin
        a_gt_b = (a > int'(guess));
        a_lt_b = (a < int'(guess));
        a_eq_b = (a == int'(guess));
        if (a == exp_g || i == 0) fin = 1'b1;
      end
      @(posedge clk); #1;
      clear_flags();
      start = 1'b0;
      i--;
    end
    check("done", done, 1);
    check("busy_in_finish", busy, 0);
    check("gvalid_in_finish", guess_valid, 0);
    check("guess_zero_in_finish", guess, 0);
    check("result", result, bad ? 0 : a);
    check("probes", probes, n);
    check("err", err, bad ? 1 : 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("result_held", result, bad ? 0 : a);
    check("err_held", err, bad ? 1 : 0);
  endtask

  initial begin
    clear_flags();
    #2;
    check("rst_guess", guess, 0);
    check("rst_gvalid", guess_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_probes", probes, 0);
    check("rst_err", err, 0);
    #20 rst_n = 1'b1;

    // Comparator traffic while idle must not start anything
    @(posedge clk); #1;
    cmp_valid = 1'b1; a_eq_b = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_ignore_gvalid", guess_valid, 0);
      check("idle_ignore_done", done, 0);
    end
    clear_flags();

    run_search(11, 0, 0, 1'b0);
    run_search(12, 0, 0, 1'b0);
    run_search(0,  0, 0, 1'b0);
    run_search(15, 0, 0, 1'b0);
    run_search(5,  5, 0, 1'b1);
    run_search(6,  0, 2, 1'b0);
    run_search(9,  0, 0, 1'b0);

    for (int k = 0; k < 20; k++)
      run_search(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, 3)), 0, 1'b0);
    run_search(int'($urandom_range(0, (1 << W) - 1)), 0, int'($urandom_range(1, 2)), 1'b0);

    // Reset while guess 12 is pending
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("pre_rst_guess8", guess, 8);
    cmp_valid = 1'b1; a_gt_b = 1'b1;
    @(posedge clk); #1;
    clear_flags();
    check("pre_rst_guess12", guess, 12);
    rst_n = 1'b0;
    #1;
    check("async_rst_guess", guess, 0);
    check("async_rst_gvalid", guess_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_result", result, 0);
    check("async_rst_probes", probes, 0);
    check("async_rst_err", err, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("post_rst_idle", guess_valid, 0);
    end
    run_search(13, 1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
